ifetch: RTL and testbench

IFETCH -- requirements
Module: ifetch

---
 rtl/ifetch.sv | 145 ++++++++++++++
 tb/tb_ifetch.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/ifetch.sv
//==============================================================================
// Module   : ifetch
// Brief    : Instruction fetch unit: single-outstanding memory reads feeding a
//            small prefetch FIFO, with redirect support. Defining the macro
//            IFETCH_MISALIGN_FAULT_EN enables the misaligned-redirect fault.
// Revision : 1.0
//==============================================================================
`default_nettype none

module ifetch #(
    parameter int                    DATA_WIDTH = 32,
    parameter int                    FIFO_DEPTH = 2,
    parameter logic [DATA_WIDTH-1:0] RESET_PC   = '0
) (
    input  logic                  clk,
    input  logic                  rst_n,
    output logic                  imem_req,
    output logic [DATA_WIDTH-1:0] imem_addr,
    input  logic [DATA_WIDTH-1:0] imem_rdata,
    input  logic                  redirect,
    input  logic [DATA_WIDTH-1:0] redirect_pc,
    output logic                  instr_valid,
    input  logic                  instr_ready,
    output logic [DATA_WIDTH-1:0] instr,
    output logic [DATA_WIDTH-1:0] instr_pc,
    output logic                  fetch_fault
);

    localparam int                    c_PTR_W   = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int                    c_CNT_W   = c_PTR_W + 1;
    localparam int                    c_OCC_W   = c_CNT_W + 1;
    localparam logic [DATA_WIDTH-1:0] c_PC_STEP = DATA_WIDTH'(4);
    localparam logic [c_PTR_W-1:0]    c_PTR_MAX = c_PTR_W'(FIFO_DEPTH - 1);

    logic [DATA_WIDTH-1:0] fetch_pc_q, fetch_pc_d;
    logic                  inflight_q, inflight_d;
    logic [DATA_WIDTH-1:0] inflight_pc_q, inflight_pc_d;
    logic [DATA_WIDTH-1:0] fifo_instr_q [FIFO_DEPTH];
    logic [DATA_WIDTH-1:0] fifo_instr_d [FIFO_DEPTH];
    logic [DATA_WIDTH-1:0] fifo_pc_q    [FIFO_DEPTH];
    logic [DATA_WIDTH-1:0] fifo_pc_d    [FIFO_DEPTH];
    logic [c_PTR_W-1:0]    rd_ptr_q, rd_ptr_d;
    logic [c_PTR_W-1:0]    wr_ptr_q, wr_ptr_d;
    logic [c_CNT_W-1:0]    count_q, count_d;
    logic                  fault_q, fault_d;

    logic                  w_pop;
    logic                  w_push;
    logic                  w_req;
    logic                  w_room;
    logic [c_OCC_W-1:0]    w_occ;
    logic [DATA_WIDTH-1:0] w_target;
    logic                  w_misaligned;

`ifdef IFETCH_MISALIGN_FAULT_EN
    assign w_target     = redirect_pc;
    assign w_misaligned = |redirect_pc[1:0];
    assign fetch_fault  = rst_n & fault_q;
`else
    assign w_target     = redirect_pc & {{(DATA_WIDTH-2){1'b1}}, 2'b00};
    assign w_misaligned = 1'b0;
    assign fetch_fault  = 1'b0;
`endif

    // Outputs are forced quiet while reset is asserted, even before the first edge.
    assign instr_valid = rst_n && (count_q != '0);
    assign instr       = rst_n ? fifo_instr_q[rd_ptr_q] : '0;
    assign instr_pc    = rst_n ? fifo_pc_q[rd_ptr_q]    : '0;
    assign imem_addr   = fetch_pc_q;
    assign imem_req    = w_req;

    always_comb begin
        w_pop  = instr_valid && instr_ready;
        w_push = inflight_q && !redirect;
        // Occupancy counts the word already on its way back so the FIFO never overflows.
        w_occ  = c_OCC_W'(count_q) + c_OCC_W'(inflight_q) - c_OCC_W'(w_pop);
        w_room = (w_occ < c_OCC_W'(FIFO_DEPTH));
        w_req  = rst_n && !redirect && !fault_q && w_room;
    end

    always_comb begin
        fetch_pc_d    = fetch_pc_q;
        inflight_d    = inflight_q;
        inflight_pc_d = inflight_pc_q;
        fifo_instr_d  = fifo_instr_q;
        fifo_pc_d     = fifo_pc_q;
        rd_ptr_d      = rd_ptr_q;
        wr_ptr_d      = wr_ptr_q;
        count_d       = count_q;
        fault_d       = fault_q;

        if (redirect) begin
            fetch_pc_d = w_target;
            inflight_d = 1'b0;
            rd_ptr_d   = '0;
            wr_ptr_d   = '0;
            count_d    = '0;
            fault_d    = w_misaligned;
        end else begin
            inflight_d = w_req;
            if (w_req) begin
                inflight_pc_d = fetch_pc_q;
                fetch_pc_d    = fetch_pc_q + c_PC_STEP;
            end
            if (w_push) begin
                fifo_instr_d[wr_ptr_q] = imem_rdata;
                fifo_pc_d[wr_ptr_q]    = inflight_pc_q;
                wr_ptr_d = (wr_ptr_q == c_PTR_MAX) ? '0 : wr_ptr_q + 1'b1;
            end
            if (w_pop) begin
                rd_ptr_d = (rd_ptr_q == c_PTR_MAX) ? '0 : rd_ptr_q + 1'b1;
            end
            count_d = count_q + c_CNT_W'(w_push) - c_CNT_W'(w_pop);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            fetch_pc_q    <= RESET_PC;
            inflight_q    <= 1'b0;
            inflight_pc_q <= '0;
            rd_ptr_q      <= '0;
            wr_ptr_q      <= '0;
            count_q       <= '0;
            fault_q       <= 1'b0;
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                fifo_instr_q[i] <= '0;
                fifo_pc_q[i]    <= '0;
            end
        end else begin
            fetch_pc_q    <= fetch_pc_d;
            inflight_q    <= inflight_d;
            inflight_pc_q <= inflight_pc_d;
            rd_ptr_q      <= rd_ptr_d;
            wr_ptr_q      <= wr_ptr_d;
            count_q       <= count_d;
            fault_q       <= fault_d;
            fifo_instr_q  <= fifo_instr_d;
            fifo_pc_q     <= fifo_pc_d;
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_ifetch.sv
//==============================================================================
// Module   : tb_ifetch
// Brief    : Directed bench for ifetch with a queue-based reference model and a
//            one-cycle-latency instruction memory (word = 0xC0DE0000 ^ address).
// Revision : 1.0
//==============================================================================
`default_nettype none

module tb_ifetch;

    localparam int          DW    = 32;
    localparam int          DEPTH = 2;
    localparam logic [31:0] RPC   = 32'h0000_0000;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          imem_req;
    logic [DW-1:0] imem_addr;
    logic [DW-1:0] imem_rdata;
    logic          redirect;
    logic [DW-1:0] redirect_pc;
    logic          instr_valid;
    logic          instr_ready;
    logic [DW-1:0] instr;
    logic [DW-1:0] instr_pc;
    logic          fetch_fault;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    ifetch #(
        .DATA_WIDTH (DW),
        .FIFO_DEPTH (DEPTH),
        .RESET_PC   (RPC)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_rdata  (imem_rdata),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .instr_valid (instr_valid),
        .instr_ready (instr_ready),
        .instr       (instr),
        .instr_pc    (instr_pc),
        .fetch_fault (fetch_fault)
    );

    function automatic logic [31:0] rom(input logic [31:0] a);
        return 32'hC0DE_0000 ^ a;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at time %0t", name, act, exp, $time);
        end
    endtask

    // Memory: answer exactly one cycle after a sampled request, garbage otherwise.
    logic        s_req = 1'b0;
    logic [31:0] s_addr = '0;
    always @(negedge clk) begin
        s_req  = imem_req;
        s_addr = imem_addr;
    end
    always @(posedge clk) begin
        #1;
        imem_rdata = s_req ? rom(s_addr) : 32'hDEAD_BEEF;
    end

    // Reference model: queue of buffered PCs, one optional outstanding fetch.
    int          m_q[$];
    bit          m_infl  = 1'b0;
    logic [31:0] m_infl_pc = '0;
    logic [31:0] m_fpc   = RPC;
    bit          m_fault = 1'b0;

    always @(negedge clk) begin
        bit e_valid;
        bit e_pop;
        bit e_req;
        e_valid = rst_n && (m_q.size() > 0);
        e_pop   = e_valid && instr_ready;
        e_req   = rst_n && !redirect && !m_fault &&
                  ((m_q.size() + int'(m_infl) - int'(e_pop)) < DEPTH);

        chk("instr_valid", {31'b0, instr_valid}, {31'b0, e_valid});
        chk("imem_req", {31'b0, imem_req}, {31'b0, e_req});
        chk("fetch_fault", {31'b0, fetch_fault}, {31'b0, rst_n && m_fault});
        if (!rst_n) begin
            chk("instr_rst", instr, 32'h0);
            chk("instr_pc_rst", instr_pc, 32'h0);
        end else if (e_valid) begin
            chk("instr", instr, rom(m_q[0]));
            chk("instr_pc", instr_pc, m_q[0]);
        end
        if (rst_n && !m_fault) chk("imem_addr", imem_addr, m_fpc);

        if (!rst_n) begin
            m_q.delete();
            m_infl  = 1'b0;
            m_fpc   = RPC;
            m_fault = 1'b0;
        end else if (redirect) begin
            m_q.delete();
            m_infl = 1'b0;
`ifdef IFETCH_MISALIGN_FAULT_EN
            m_fpc   = redirect_pc;
            m_fault = (redirect_pc[1:0] != 2'b00);
`else
            m_fpc   = {redirect_pc[31:2], 2'b00};
            m_fault = 1'b0;
`endif
        end else begin
            if (e_pop) void'(m_q.pop_front());
            if (m_infl) m_q.push_back(m_infl_pc);
            m_infl = e_req;
            if (e_req) begin
                m_infl_pc = m_fpc;
                m_fpc     = m_fpc + 32'd4;
            end
        end
    end

    task automatic cyc_start();
        @(posedge clk);
        #1;
    endtask

    task automatic mid();
        @(negedge clk);
    endtask

    logic [15:0] ready_pat = 16'b1011_0010_1110_0101;

    initial begin
        rst_n       = 1'b0;
        redirect    = 1'b0;
        redirect_pc = '0;
        instr_ready = 1'b1;
        imem_rdata  = 32'hDEAD_BEEF;

        repeat (3) cyc_start();
        mid();
        chk("rst_req", {31'b0, imem_req}, 32'd0);
        chk("rst_valid", {31'b0, instr_valid}, 32'd0);
        chk("rst_instr", instr, 32'h0);
        chk("rst_fault", {31'b0, fetch_fault}, 32'd0);

        // Fill and stream A,B,C,D
        cyc_start(); rst_n = 1'b1;
        mid(); chk("c0_req", {31'b0, imem_req}, 32'd1); chk("c0_addr", imem_addr, 32'h0);
        cyc_start(); mid(); chk("c1_valid", {31'b0, instr_valid}, 32'd0);
        cyc_start(); mid();
        chk("c2_valid", {31'b0, instr_valid}, 32'd1);
        chk("c2_pc", instr_pc, 32'h0);
        chk("c2_instr", instr, 32'hC0DE_0000);
        cyc_start(); mid(); chk("c3_pc", instr_pc, 32'h4); chk("c3_instr", instr, 32'hC0DE_0004);
        cyc_start(); mid(); chk("c4_pc", instr_pc, 32'h8);
        cyc_start(); mid(); chk("c5_pc", instr_pc, 32'hC); chk("c5_instr", instr, 32'hC0DE_000C);

        // One-cycle reset mid-stream, then stall from cycle 2 for 5 cycles
        cyc_start(); rst_n = 1'b0;
        mid(); chk("mrst_valid", {31'b0, instr_valid}, 32'd0);
        cyc_start(); rst_n = 1'b1;
        mid(); chk("mrst_c0_valid", {31'b0, instr_valid}, 32'd0); chk("mrst_c0_addr", imem_addr, RPC);
        cyc_start();
        cyc_start(); instr_ready = 1'b0;
        repeat (4) cyc_start();
        mid();
        chk("stall_valid", {31'b0, instr_valid}, 32'd1);
        chk("stall_pc", instr_pc, 32'h0);
        chk("stall_req", {31'b0, imem_req}, 32'd0);
        cyc_start(); instr_ready = 1'b1;
        mid(); chk("rel_pc0", instr_pc, 32'h0);
        cyc_start(); mid(); chk("rel_pc1", instr_pc, 32'h4);
        cyc_start(); mid(); chk("rel_pc2", instr_pc, 32'h8);

        // Redirect to 0x40 with the FIFO full
        cyc_start(); instr_ready = 1'b0;
        repeat (2) cyc_start();
        cyc_start(); redirect = 1'b1; redirect_pc = 32'h40; instr_ready = 1'b1;
        cyc_start(); redirect = 1'b0;
        mid();
        chk("rd40_valid", {31'b0, instr_valid}, 32'd0);
        chk("rd40_req", {31'b0, imem_req}, 32'd1);
        chk("rd40_addr", imem_addr, 32'h40);
        cyc_start(); cyc_start(); mid();
        chk("rd40_pc", instr_pc, 32'h40); chk("rd40_instr", instr, 32'hC0DE_0040);

        // Back-to-back redirects while streaming
        repeat (3) cyc_start();
        cyc_start(); redirect = 1'b1; redirect_pc = 32'h100;
        cyc_start(); redirect_pc = 32'h200;
        cyc_start(); redirect = 1'b0;
        mid(); chk("b2b_addr", imem_addr, 32'h200);
        cyc_start(); cyc_start(); mid(); chk("b2b_pc", instr_pc, 32'h200);

        // Address wrap
        cyc_start(); redirect = 1'b1; redirect_pc = 32'hFFFF_FFF8;
        cyc_start(); redirect = 1'b0;
        cyc_start(); cyc_start(); mid(); chk("wrap_pc0", instr_pc, 32'hFFFF_FFF8);
        cyc_start(); mid(); chk("wrap_pc1", instr_pc, 32'hFFFF_FFFC);
        cyc_start(); mid(); chk("wrap_pc2", instr_pc, 32'h0); chk("wrap_instr2", instr, 32'hC0DE_0000);

        // Irregular decoder back-pressure
        for (int i = 0; i < 16; i++) begin
            cyc_start(); instr_ready = ready_pat[i];
        end
        cyc_start(); instr_ready = 1'b1;
        repeat (3) cyc_start();

        // Misaligned redirect
        cyc_start(); redirect = 1'b1; redirect_pc = 32'h42;
        cyc_start(); redirect = 1'b0;
        mid();
`ifdef IFETCH_MISALIGN_FAULT_EN
        chk("mis_fault", {31'b0, fetch_fault}, 32'd1);
        chk("mis_req", {31'b0, imem_req}, 32'd0);
        repeat (3) cyc_start();
        mid();
        chk("mis_hold_req", {31'b0, imem_req}, 32'd0);
        chk("mis_hold_valid", {31'b0, instr_valid}, 32'd0);
        cyc_start(); redirect = 1'b1; redirect_pc = 32'h80;
        cyc_start(); redirect = 1'b0;
        mid();
        chk("clr_fault", {31'b0, fetch_fault}, 32'd0);
        chk("clr_req", {31'b0, imem_req}, 32'd1);
        chk("clr_addr", imem_addr, 32'h80);
        cyc_start(); cyc_start(); mid(); chk("clr_pc", instr_pc, 32'h80);
`else
        chk("mis_req", {31'b0, imem_req}, 32'd1);
        chk("mis_addr", imem_addr, 32'h40);
        cyc_start(); cyc_start(); mid(); chk("mis_pc", instr_pc, 32'h40);
`endif

        repeat (4) cyc_start();
        mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
